// File: rtl/console_scroll_controller.sv
`default_nettype none
// ============================================================================
//  Module      : console_scroll_controller
//  Description : Ring of LINES text lines (32 chars each). New lines are
//                committed by bumping the head pointer; every commit or
//                refresh triggers a sweep that writes the visible characters
//                into the character display RAM, oldest line at the top.
//  Revision    : 1.0 - initial release
// ============================================================================
module console_scroll_controller #(
  parameter int          LINES      = 8,
  parameter int          VIS_COLS   = 11,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         line_push,
  input  logic [255:0] line_content,
  input  logic         refresh,
  output logic         line_ready,
  output logic [7:0]   char_index,
  output logic [7:0]   char_data,
  output logic         char_we,
  output logic         busy,
  output logic         finish,
  output logic         overflow
);

  localparam int HW = $clog2(LINES);
  localparam logic [HW-1:0] C_LAST_ROW = HW'(LINES - 1);
  localparam logic [4:0]    C_LAST_COL = 5'(VIS_COLS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_SWEEP  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t         r_state, w_next;
  logic [255:0]   r_ring [LINES];
  logic [HW-1:0]  r_head;
  logic [255:0]   r_pending_line;
  logic           r_pending_valid;
  logic           r_refresh_pending;
  logic           r_overflow;
  logic [HW-1:0]  r_row;
  logic [4:0]     r_col;
  logic [7:0]     r_char_index;
  logic [7:0]     r_char_data;
  logic           r_char_we;
  logic           r_finish;

  logic           w_push_ok;
  logic           w_last;
  logic [HW-1:0]  w_head_inc;
  logic [HW-1:0]  w_slot;
  logic [255:0]   w_line;
  logic [7:0]     w_bitpos;
  logic [7:0]     w_byte;
  logic [7:0]     w_row8;
  logic [7:0]     w_index;

  // A push is only taken when the single pending slot is free.
  assign w_push_ok  = line_push && !r_pending_valid;
  assign w_last     = (r_row == C_LAST_ROW) && (r_col == C_LAST_COL);
  assign w_head_inc = r_head + HW'(1);

  // Row 0 shows the slot right after head, i.e. the oldest stored line.
  assign w_slot   = r_head + HW'(1) + r_row;
  assign w_line   = r_ring[w_slot];
  assign w_bitpos = 8'd255 - {r_col, 3'b000};
  assign w_byte   = w_line[w_bitpos -: 8];
  assign w_row8   = 8'(r_row);
  assign w_index  = (w_row8 << 5) | {3'b000, r_col};

  assign line_ready = !r_pending_valid;
  assign busy       = (r_state == ST_COMMIT) || (r_state == ST_SWEEP);
  assign char_index = r_char_index;
  assign char_data  = r_char_data;
  assign char_we    = r_char_we;
  assign finish     = r_finish;
  assign overflow   = r_overflow;

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic. A push accepted in IDLE holds the FSM one cycle so the
  // following COMMIT absorbs any simultaneous refresh into a single sweep.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_pending_valid)                     w_next = ST_COMMIT;
        else if (w_push_ok)                      w_next = ST_IDLE;
        else if (refresh || r_refresh_pending)   w_next = ST_SWEEP;
      end
      ST_COMMIT: w_next = ST_SWEEP;
      ST_SWEEP:  if (w_last) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Push capture, ring commit, sweep counters and registered write port.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < LINES; i++) r_ring[i] <= '0;
      r_head            <= C_LAST_ROW;
      r_pending_line    <= '0;
      r_pending_valid   <= 1'b0;
      r_refresh_pending <= 1'b0;
      r_overflow        <= 1'b0;
      r_row             <= '0;
      r_col             <= '0;
      r_char_index      <= '0;
      r_char_data       <= '0;
      r_char_we         <= 1'b0;
      r_finish          <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_pending_line  <= line_content;
        r_pending_valid <= 1'b1;
      end else if (line_push) begin
        r_overflow <= 1'b1;
      end

      // A refresh seen during COMMIT is newer than the commit, so it must
      // still produce its own sweep; earlier ones are covered by it.
      if (r_state == ST_IDLE) begin
        if (w_next != ST_IDLE) r_refresh_pending <= 1'b0;
      end else if (r_state == ST_COMMIT) begin
        r_refresh_pending <= refresh;
      end else if (refresh) begin
        r_refresh_pending <= 1'b1;
      end

      if (r_state == ST_COMMIT) begin
        r_head             <= w_head_inc;
        r_ring[w_head_inc] <= r_pending_line;
        r_pending_valid    <= 1'b0;
      end

      if (r_state == ST_SWEEP) begin
        if (r_col == C_LAST_COL) begin
          r_col <= '0;
          r_row <= r_row + HW'(1);
        end else begin
          r_col <= r_col + 5'd1;
        end
        r_char_index <= w_index;
        r_char_data  <= (w_byte == 8'h00) ? BLANK_CHAR : w_byte;
      end else begin
        r_row <= '0;
        r_col <= '0;
      end

      r_char_we <= (r_state == ST_SWEEP);
      r_finish  <= (r_state == ST_DONE);
    end
  end

endmodule
`default_nettype wire
